// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the fetch front end.
// Optional call/return support is enabled with FETCH_CALL_EN.
package fetch_pkg;

  localparam int ADDR_W_D   = 4;
  localparam int INSTR_W_D  = 9;
  localparam int RESET_PC_D = 0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction handoff bundle between fetch and datapath.
// Valid/ready handshake plus the fetch address of the held instruction.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_D,
  parameter int INSTR_W = INSTR_W_D
) ();

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic [ADDR_W-1:0]  pc_out;

  modport master (
    output instr,
    output instr_valid,
    output pc_out,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    input  pc_out,
    output instr_ready
  );

endinterface

// File: rtl/fetch_pc.sv
// Fetch program counter: load on redirect, increment on fetch, else hold.
// Wraps silently modulo 2^ADDR_W.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_D,
  parameter int RESET_PC = RESET_PC_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] fpc
);

  // Redirect wins over sequential advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc <= ADDR_W'(RESET_PC);
    end else if (load) begin
      fpc <= load_addr;
    end else if (inc) begin
      fpc <= fpc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: IDLE/RUN/HALT control, redirect, and instruction register.
// Define FETCH_CALL_EN to add call_en/ret_en with one return register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_D,
  parameter int INSTR_W  = INSTR_W_D,
  parameter int RESET_PC = RESET_PC_D
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  fetch_if.master            out,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               halt_req,
  input  logic               resume,
`ifdef FETCH_CALL_EN
  input  logic               call_en,
  input  logic               ret_en,
`endif
  output logic               halted
);

  state_t            state;
  state_t            state_nxt;
  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              fetch;
  logic [ADDR_W-1:0] fpc;

`ifdef FETCH_CALL_EN
  logic [ADDR_W-1:0] ra;

  // Redirect source: jump and call share jump_target, return uses ra
  always_comb begin
    redirect = jump_en | call_en | ret_en;
    target   = (jump_en | call_en) ? jump_target : ra;
  end

  // Return address captured only when call is the winning redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra <= '0;
    end else if (call_en && !jump_en) begin
      ra <= out.pc_out + ADDR_W'(1);
    end
  end
`else
  // Redirect source: plain jump only
  always_comb begin
    redirect = jump_en;
    target   = jump_target;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and fetch enable; fetch needs a free output slot
  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    unique case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        if (halt_req) state_nxt = HALT;
        fetch = !halt_req && !redirect &&
                (!out.instr_valid || out.instr_ready);
      end
      HALT: begin
        if (resume && !halt_req) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction register: flush on redirect, refill or drain otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out.instr       <= '0;
      out.instr_valid <= 1'b0;
      out.pc_out      <= '0;
    end else if (redirect) begin
      out.instr_valid <= 1'b0;
    end else if (fetch) begin
      out.instr       <= imem_data;
      out.pc_out      <= fpc;
      out.instr_valid <= 1'b1;
    end else if (out.instr_ready) begin
      out.instr_valid <= 1'b0;
    end
  end

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (redirect),
    .load_addr (target),
    .inc       (fetch),
    .fpc       (fpc)
  );

  assign imem_addr = fpc;
  assign halted    = (state == HALT);

endmodule
